// File: rtl/gat_cls_pkg.sv
// gat_cls_pkg: shared types and width helpers for the GAT class argmax readout.
package gat_cls_pkg;
    localparam int FEAT_W = 32;
    typedef logic signed [FEAT_W-1:0] feat_t;
    typedef enum logic [2:0] {IDLE, ISSUE, COLLECT, OUTPUT, DONE} cls_state_e;
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction
    function automatic int cls_w(input int num_feature_final);
        return clog2_min1(num_feature_final);
    endfunction
    function automatic int node_w(input int num_subgraphs);
        return clog2_min1(num_subgraphs);
    endfunction
endpackage

// File: rtl/gat_class_argmax_if.sv
// gat_class_argmax_if: BRAM port-B read bus plus the class-result valid/ready stream.
interface gat_class_argmax_if #(
    parameter int ADDR_W = 15,
    parameter int DW     = 32,
    parameter int NODE_W = 12,
    parameter int CLS_W  = 3
);
    logic              feat_bram_enb_o;
    logic [ADDR_W-1:0] feat_bram_addrb_o;
    logic [DW-1:0]     feat_bram_dout_i;
    logic              cls_vld_o;
    logic              cls_rdy_i;
    logic [NODE_W-1:0] cls_node_o;
    logic [CLS_W-1:0]  cls_idx_o;
    logic [DW-1:0]     cls_score_o;
    modport master (
        output feat_bram_enb_o, feat_bram_addrb_o, cls_vld_o, cls_node_o, cls_idx_o, cls_score_o,
        input  feat_bram_dout_i, cls_rdy_i
    );
    modport slave (
        input  feat_bram_enb_o, feat_bram_addrb_o, cls_vld_o, cls_node_o, cls_idx_o, cls_score_o,
        output feat_bram_dout_i, cls_rdy_i
    );
endinterface

// File: rtl/gat_argmax_acc.sv
// gat_argmax_acc: running signed max over one node's logits; ties keep the lowest index.
module gat_argmax_acc #(
    parameter int W     = 32,
    parameter int CLS_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_i,
    input  logic                upd_i,
    input  logic [CLS_W-1:0]    fidx_i,
    input  logic signed [W-1:0] din_i,
    output logic [CLS_W-1:0]    idx_o,
    output logic signed [W-1:0] score_o
);
    logic [CLS_W-1:0]    idx_q, idx_d;
    logic signed [W-1:0] score_q, score_d;
    logic                take;
    always_comb begin
        take    = ld_i || (upd_i && (din_i > score_q));
        idx_d   = take ? fidx_i : idx_q;
        score_d = take ? din_i : score_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            score_q <= '0;
        end else begin
            idx_q   <= idx_d;
            score_q <= score_d;
        end
    end
    assign idx_o   = idx_q;
    assign score_o = score_q;
endmodule

// File: rtl/gat_class_argmax.sv
// gat_class_argmax: walks the conv2 feature BRAM and streams per-node argmax class and score.
// Define GAT_CLS_HIST_EN to add cls_hist_o, saturating per-class result counters.
module gat_class_argmax
    import gat_cls_pkg::*;
#(
    parameter int NUM_SUBGRAPHS     = 2708,
    parameter int NUM_FEATURE_FINAL = 7,
    parameter int NEW_FEATURE_WIDTH = 32,
    parameter int BRAM_RD_LAT       = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic gat_ready_i,
    gat_class_argmax_if.master bus,
    output logic busy_o,
    output logic done_o
`ifdef GAT_CLS_HIST_EN
    ,
    output logic [NUM_FEATURE_FINAL*16-1:0] cls_hist_o
`endif
);
    localparam int F      = NUM_FEATURE_FINAL;
    localparam int N      = NUM_SUBGRAPHS;
    localparam int L      = BRAM_RD_LAT;
    localparam int ADDR_W = clog2_min1(N * F);
    localparam int CLS_W  = cls_w(F);
    localparam int NODE_W = node_w(N);
    localparam int TW     = CLS_W + 2;

    cls_state_e                    state_q, state_d;
    logic [NODE_W-1:0]             node_q, node_d;
    logic [CLS_W-1:0]              f_q, f_d;
    logic [ADDR_W-1:0]             base_q, base_d, addr_q, addr_d, cur_addr;
    logic                          prev_q, prev_d;
    logic [TW-1:0]                 dl_q [L];
    logic [TW-1:0]                 dl_d [L];
    logic                          start, issue, hs, f_last, node_last;
    logic                          tap_vld, tap_last;
    logic [CLS_W-1:0]              tap_f, idx;
    logic signed [NEW_FEATURE_WIDTH-1:0] score;

    assign issue     = state_q == ISSUE;
    assign hs        = (state_q == OUTPUT) && bus.cls_rdy_i;
    assign start     = (state_q == IDLE) && gat_ready_i && !prev_q;
    assign cur_addr  = base_q + ADDR_W'(f_q);
    assign f_last    = f_q == CLS_W'(F - 1);
    assign node_last = node_q == NODE_W'(N - 1);
    assign {tap_vld, tap_last, tap_f} = dl_q[L-1];

    // Each issued read carries {valid, last, feature index} down a BRAM_RD_LAT-deep line.
    always_comb begin
        state_d = state_q;
        node_d  = node_q;
        f_d     = f_q;
        base_d  = base_q;
        addr_d  = addr_q;
        prev_d  = gat_ready_i;
        dl_d[0] = {issue, issue && f_last, f_q};
        for (int i = 1; i < L; i++) dl_d[i] = dl_q[i-1];
        unique case (state_q)
            IDLE: if (start) begin
                state_d = ISSUE;
                node_d  = '0;
                f_d     = '0;
                base_d  = '0;
            end
            ISSUE: begin
                addr_d  = cur_addr;
                f_d     = f_last ? '0 : f_q + CLS_W'(1);
                state_d = f_last ? COLLECT : ISSUE;
            end
            COLLECT: state_d = (tap_vld && tap_last) ? OUTPUT : COLLECT;
            OUTPUT: if (hs) begin
                state_d = node_last ? DONE : ISSUE;
                node_d  = node_last ? node_q : node_q + NODE_W'(1);
                base_d  = node_last ? base_q : base_q + ADDR_W'(F);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            node_q  <= '0;
            f_q     <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            prev_q  <= 1'b1;
            dl_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            node_q  <= node_d;
            f_q     <= f_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            prev_q  <= prev_d;
            dl_q    <= dl_d;
        end
    end

    gat_argmax_acc #(.W(NEW_FEATURE_WIDTH), .CLS_W(CLS_W)) u_acc (
        .clk     (clk),
        .rst     (rst),
        .ld_i    (tap_vld && (tap_f == '0)),
        .upd_i   (tap_vld && (tap_f != '0)),
        .fidx_i  (tap_f),
        .din_i   (bus.feat_bram_dout_i),
        .idx_o   (idx),
        .score_o (score)
    );

    assign bus.feat_bram_enb_o   = issue;
    assign bus.feat_bram_addrb_o = issue ? cur_addr : addr_q;
    assign bus.cls_vld_o         = state_q == OUTPUT;
    assign bus.cls_node_o        = node_q;
    assign bus.cls_idx_o         = idx;
    assign bus.cls_score_o       = score;
    assign busy_o                = state_q != IDLE;
    assign done_o                = state_q == DONE;

`ifdef GAT_CLS_HIST_EN
    logic [15:0] hist_q [F];
    logic [15:0] hist_d [F];
    always_comb begin
        for (int k = 0; k < F; k++)
            hist_d[k] = start ? 16'd0 :
                        (hs && idx == CLS_W'(k) && hist_q[k] != 16'hFFFF) ? hist_q[k] + 16'd1 : hist_q[k];
    end
    always_ff @(posedge clk) begin
        if (rst) hist_q <= '{default: '0};
        else     hist_q <= hist_d;
    end
    for (genvar k = 0; k < F; k++) begin : g_hist
        assign cls_hist_o[k*16 +: 16] = hist_q[k];
    end
`endif
endmodule

// File: tb/tb_gat_class_argmax.sv
// tb_gat_class_argmax: directed checks of a 5-node, 7-class, latency-2 readout pass.
module tb_gat_class_argmax;
    localparam int N = 5, F = 7, L = 2;
    localparam int ADDR_W = $clog2(N * F), NODE_W = $clog2(N), CLS_W = $clog2(F);

    logic clk = 0, rst = 1, gat_ready_i = 1, busy_o, done_o;
`ifdef GAT_CLS_HIST_EN
    logic [F*16-1:0] cls_hist_o;
`endif
    int total = 0, bad = 0;
    logic [31:0] mem [N*F];
    logic [31:0] p1;

    gat_class_argmax_if #(.ADDR_W(ADDR_W), .DW(32), .NODE_W(NODE_W), .CLS_W(CLS_W)) bus ();

    gat_class_argmax #(.NUM_SUBGRAPHS(N), .NUM_FEATURE_FINAL(F), .NEW_FEATURE_WIDTH(32), .BRAM_RD_LAT(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .gat_ready_i (gat_ready_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .done_o      (done_o)
`ifdef GAT_CLS_HIST_EN
        ,
        .cls_hist_o  (cls_hist_o)
`endif
    );

    always #5 clk = ~clk;

    // Two-cycle BRAM: address sampled at the edge, data on dout two cycles after enb.
    always @(posedge clk) begin
        p1 <= bus.feat_bram_enb_o ? mem[int'(bus.feat_bram_addrb_o)] : 32'hDEADBEEF;
        bus.feat_bram_dout_i <= p1;
    end

    int          exp_ix [N] = '{1, 1, 1, 6, 2};
    logic [31:0] exp_sc [N] = '{32'h00050000, 32'h00040000, 32'hFFFD0000, 32'h80000001, 32'h00070000};

    task automatic load_a();
        int va [N*F] = '{1, 5, 3, 0, 0, 0, 0,  -2, 4, 4, 4, -1, 0, 4,  -8, -3, -5, -3, -9, -7, -4,
                         0, 0, 0, 0, 0, 0, 0,  3, -1, 7, 7, 2, 0, 6};
        for (int i = 0; i < N*F; i++) mem[i] = 32'(va[i]) << 16;
        for (int i = 21; i < 27; i++) mem[i] = 32'h80000000;
        mem[27] = 32'h80000001;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy_o !== 0 || done_o !== 0) begin bad++; $display("FAIL reset_status: busy=%b done=%b want 0 0", busy_o, done_o); end
        total++; if (bus.cls_vld_o !== 0 || bus.feat_bram_enb_o !== 0) begin bad++; $display("FAIL reset_strobes: vld=%b enb=%b want 0 0", bus.cls_vld_o, bus.feat_bram_enb_o); end
        total++; if (bus.feat_bram_addrb_o !== 0 || bus.cls_node_o !== 0 || bus.cls_idx_o !== 0 || bus.cls_score_o !== 0) begin bad++;
            $display("FAIL reset_data: addr=%0h node=%0h idx=%0h score=%0h want all 0", bus.feat_bram_addrb_o, bus.cls_node_o, bus.cls_idx_o, bus.cls_score_o); end
        rst = 0;
        begin
            int seen = 0;
            for (int c = 0; c < 8; c++) begin @(posedge clk); #1; if (busy_o) seen++; end
            total++; if (seen !== 0) begin bad++; $display("FAIL held_level_start: busy cycles=%0d want 0", seen); end
        end
        gat_ready_i = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_pass();
        int t = -1, nres = 0, nenb = 0;
        bit fin = 0;
        bus.cls_rdy_i = 1;
        gat_ready_i = 1;
        for (int c = 0; c < 200 && !fin; c++) begin
            @(posedge clk); #1;
            if (t >= 0) t++; else if (busy_o) t = 0;
            if (bus.feat_bram_enb_o) begin
                total++; if (bus.feat_bram_addrb_o !== ADDR_W'(nenb)) begin bad++; $display("FAIL pass_addr: got %0d want %0d", bus.feat_bram_addrb_o, nenb); end
                nenb++;
            end
            if (bus.cls_vld_o && nres < N) begin
                total++; if (bus.cls_node_o !== NODE_W'(nres) || bus.cls_idx_o !== CLS_W'(exp_ix[nres]) || bus.cls_score_o !== exp_sc[nres]) begin bad++;
                    $display("FAIL pass_result: node=%0d idx=%0d score=%h want node=%0d idx=%0d score=%h", bus.cls_node_o, bus.cls_idx_o, bus.cls_score_o, nres, exp_ix[nres], exp_sc[nres]); end
                total++; if (t !== 10*nres + 9) begin bad++; $display("FAIL pass_latency: node %0d at cycle %0d want %0d", nres, t, 10*nres + 9); end
                nres++;
            end
            if (done_o) begin
                total++; if (t !== 50) begin bad++; $display("FAIL pass_length: done at cycle %0d want 50", t); end
                fin = 1;
            end
        end
        total++; if (!fin) begin bad++; $display("FAIL pass_timeout: done=0 want 1"); end
        total++; if (nres !== N || nenb !== N*F) begin bad++; $display("FAIL pass_counts: results=%0d reads=%0d want %0d %0d", nres, nenb, N, N*F); end
        @(posedge clk); #1;
        total++; if (done_o !== 0 || busy_o !== 0) begin bad++; $display("FAIL done_pulse: done=%b busy=%b want 0 0", done_o, busy_o); end
        gat_ready_i = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int t = -1, nres = 0, stall_bad = 0;
        bit fin = 0, held = 0;
        gat_ready_i = 1;
        for (int c = 0; c < 300 && !fin; c++) begin
            @(posedge clk); #1;
            if (t >= 0) t++; else if (busy_o) t = 0;
            if (bus.cls_vld_o && nres < N) begin
                total++; if (bus.cls_node_o !== NODE_W'(nres) || bus.cls_idx_o !== CLS_W'(exp_ix[nres]) || t !== 10*nres + 9 + (nres >= 2 ? 10 : 0)) begin bad++;
                    $display("FAIL bp_result: node=%0d idx=%0d cycle=%0d want node=%0d idx=%0d", bus.cls_node_o, bus.cls_idx_o, t, nres, exp_ix[nres]); end
                if (nres == 1 && !held) begin
                    held = 1;
                    bus.cls_rdy_i = 0;
                    for (int h = 0; h < 10; h++) begin
                        @(posedge clk); #1;
                        if (bus.cls_vld_o !== 1 || bus.cls_node_o !== 1 || bus.cls_idx_o !== 1 || bus.cls_score_o !== 32'h00040000 || bus.feat_bram_enb_o !== 0) stall_bad++;
                    end
                    total++; if (stall_bad !== 0) begin bad++; $display("FAIL bp_stable: unstable cycles=%0d want 0", stall_bad); end
                    bus.cls_rdy_i = 1;
                    t += 10;
                end
                nres++;
            end
            if (done_o) begin
                total++; if (t !== 60 || nres !== N) begin bad++; $display("FAIL bp_length: done at %0d results=%0d want 60 %0d", t, nres, N); end
                fin = 1;
            end
        end
        total++; if (!fin) begin bad++; $display("FAIL bp_timeout: done=0 want 1"); end
        gat_ready_i = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit hit = 0, got = 0, fin = 0;
        int seen = 0;
        gat_ready_i = 1;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(posedge clk); #1;
            if (bus.feat_bram_enb_o && bus.feat_bram_addrb_o == ADDR_W'(10)) hit = 1;
        end
        total++; if (!hit) begin bad++; $display("FAIL mid_reach: addr 10 issue seen=0 want 1"); end
        rst = 1;
        @(posedge clk); #1;
        total++; if (busy_o !== 0 || done_o !== 0 || bus.cls_vld_o !== 0 || bus.feat_bram_enb_o !== 0) begin bad++;
            $display("FAIL mid_rst_status: busy=%b done=%b vld=%b enb=%b want 0", busy_o, done_o, bus.cls_vld_o, bus.feat_bram_enb_o); end
        total++; if (bus.feat_bram_addrb_o !== 0 || bus.cls_node_o !== 0 || bus.cls_idx_o !== 0 || bus.cls_score_o !== 0) begin bad++;
            $display("FAIL mid_rst_data: addr=%0h node=%0h idx=%0h score=%h want 0", bus.feat_bram_addrb_o, bus.cls_node_o, bus.cls_idx_o, bus.cls_score_o); end
        rst = 0;
        for (int c = 0; c < 30; c++) begin @(posedge clk); #1; if (busy_o || bus.cls_vld_o) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_no_restart: active cycles=%0d want 0", seen); end
        gat_ready_i = 0;
        @(posedge clk); #1;
        gat_ready_i = 1;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #1;
            if (bus.feat_bram_enb_o) begin
                got = 1;
                total++; if (bus.feat_bram_addrb_o !== 0) begin bad++; $display("FAIL restart_addr: got %0d want 0", bus.feat_bram_addrb_o); end
            end
        end
        total++; if (!got) begin bad++; $display("FAIL restart_issue: enb=0 want 1"); end
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(posedge clk); #1;
            if (bus.cls_vld_o) begin
                got = 1;
                total++; if (bus.cls_node_o !== 0 || bus.cls_idx_o !== 1 || bus.cls_score_o !== 32'h00050000) begin bad++;
                    $display("FAIL restart_result: node=%0d idx=%0d score=%h want 0 1 00050000", bus.cls_node_o, bus.cls_idx_o, bus.cls_score_o); end
            end
        end
        total++; if (!got) begin bad++; $display("FAIL restart_vld: vld=0 want 1"); end
        for (int c = 0; c < 100 && !fin; c++) begin @(posedge clk); #1; if (done_o) fin = 1; end
        total++; if (!fin) begin bad++; $display("FAIL restart_done: done=0 want 1"); end
        gat_ready_i = 0;
        @(posedge clk); #1;
    endtask

`ifdef GAT_CLS_HIST_EN
    task automatic test_hist();
        int cls [N] = '{2, 2, 0, 6, 2};
        int eh [F] = '{1, 0, 3, 0, 0, 0, 1};
        bit fin = 0;
        for (int i = 0; i < N*F; i++) mem[i] = 32'h0;
        for (int n = 0; n < N; n++) mem[n*F + cls[n]] = 32'h00010000;
        gat_ready_i = 1;
        for (int c = 0; c < 200 && !fin; c++) begin @(posedge clk); #1; if (done_o) fin = 1; end
        total++; if (!fin) begin bad++; $display("FAIL hist_done: done=0 want 1"); end
        @(posedge clk); #1;
        for (int k = 0; k < F; k++) begin
            total++; if (cls_hist_o[k*16 +: 16] !== 16'(eh[k])) begin bad++; $display("FAIL hist_%0d: got %0d want %0d", k, cls_hist_o[k*16 +: 16], eh[k]); end
        end
        gat_ready_i = 0;
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        bus.cls_rdy_i = 1;
        load_a();
        test_reset();
        test_pass();
        test_backpressure();
        test_reset_mid();
`ifdef GAT_CLS_HIST_EN
        test_hist();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
